// File: rtl/if_id_hazard_reg.sv
// IF/ID pipeline register that carries out stall (hold + ID/EX bubble) and flush (wrong-path squash) requests.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module if_id_hazard_reg #(
    parameter int unsigned FLUSH_DEPTH = 1,
    parameter int unsigned MAX_STALL   = 15,
    parameter logic [31:0] NOP         = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bubble_stop,
    input  logic        flush,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_inst,
    output logic        pc_write,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic        id_ex_bubble,
    output logic        stall_timeout,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        SQUASH = 2'd2
    } state_t;

    localparam logic [1:0] SQ_RELOAD   = 2'(FLUSH_DEPTH - 1);
    localparam bit         MULTI_SQ    = (FLUSH_DEPTH > 1);
    localparam logic [7:0] STALL_LIMIT = 8'(MAX_STALL);

    state_t      state_q, state_d;
    logic [1:0]  sq_left_q, sq_left_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_valid_q, id_valid_d;
    logic [7:0]  stall_run_q, stall_run_d;
    logic        timeout_q, timeout_d;
    logic        stall_req;

    // A flush always wins, and a squash in progress cannot be held off by a stall.
    assign stall_req = bubble_stop & ~flush & (state_q != SQUASH);

    assign pc_write      = ~stall_req;
    assign id_ex_bubble  = stall_req;
    assign id_pc         = id_pc_q;
    assign id_inst       = id_inst_q;
    assign id_valid      = id_valid_q;
    assign stall_timeout = timeout_q;

    always_comb begin
        state_d    = state_q;
        sq_left_d  = sq_left_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;

        if (flush) begin
            id_pc_d    = if_pc;
            id_inst_d  = NOP;
            id_valid_d = 1'b0;
            sq_left_d  = SQ_RELOAD;
            state_d    = MULTI_SQ ? SQUASH : RUN;
        end else begin
            case (state_q)
                RUN, STALL: begin
                    if (bubble_stop) begin
                        state_d = STALL;
                    end else begin
                        id_pc_d    = if_pc;
                        id_inst_d  = if_inst;
                        id_valid_d = 1'b1;
                        state_d    = RUN;
                    end
                end
                SQUASH: begin
                    id_pc_d    = if_pc;
                    id_inst_d  = NOP;
                    id_valid_d = 1'b0;
                    sq_left_d  = (sq_left_q == 2'd0) ? 2'd0 : sq_left_q - 2'd1;
                    if (sq_left_q <= 2'd1) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_comb begin
        stall_run_d = 8'd0;
        if (stall_req) begin
            stall_run_d = (stall_run_q == 8'hFF) ? 8'hFF : stall_run_q + 8'd1;
        end
        timeout_d = timeout_q | (stall_req & (stall_run_d == STALL_LIMIT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            sq_left_q   <= 2'd0;
            id_pc_q     <= 32'd0;
            id_inst_q   <= NOP;
            id_valid_q  <= 1'b0;
            stall_run_q <= 8'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sq_left_q   <= sq_left_d;
            id_pc_q     <= id_pc_d;
            id_inst_q   <= id_inst_d;
            id_valid_q  <= id_valid_d;
            stall_run_q <= stall_run_d;
            timeout_q   <= timeout_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (stall_req) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_id_hazard_reg.sv
// Scoreboard bench for if_id_hazard_reg: directed hazard scenarios plus random traffic against a cycle-level reference model.
module tb_if_id_hazard_reg;

    localparam int          FD    = 2;
    localparam int          MS    = 4;
    localparam logic [31:0] NOP_W = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bubble_stop = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] if_pc = 32'd0;
    logic [31:0] if_inst = 32'd0;
    logic        pc_write;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        id_ex_bubble;
    logic        stall_timeout;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    if_id_hazard_reg #(
        .FLUSH_DEPTH(FD),
        .MAX_STALL  (MS),
        .NOP        (NOP_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bubble_stop  (bubble_stop),
        .flush        (flush),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .pc_write     (pc_write),
        .id_pc        (id_pc),
        .id_inst      (id_inst),
        .id_valid     (id_valid),
        .id_ex_bubble (id_ex_bubble),
        .stall_timeout(stall_timeout),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        pcw;
        logic        bub;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        vld;
        logic        to;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t q[$];

    // reference model: what decode currently sees, plus squash/stall bookkeeping
    int          m_sq;
    int          m_run;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic        m_vld;
    logic        m_to;
    logic [31:0] m_sc;
    logic [31:0] m_fc;
    logic [31:0] pc_ctr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sq   = 0;
        m_run  = 0;
        m_pc   = 32'd0;
        m_inst = NOP_W;
        m_vld  = 1'b0;
        m_to   = 1'b0;
        m_sc   = 32'd0;
        m_fc   = 32'd0;
    endtask

    // Called just after a rising edge; drives one cycle of inputs and advances the model over the next edge.
    task automatic cycle(input logic bs, input logic fl, input logic [31:0] pc, input logic [31:0] inst);
        logic stall;
        logic squashing;
        exp_t e;
        bubble_stop = bs;
        flush       = fl;
        if_pc       = pc;
        if_inst     = inst;
        squashing   = (m_sq > 0);
        stall       = bs && !fl && !squashing;
        e.pcw  = !stall;
        e.bub  = stall;
        e.pc   = m_pc;
        e.inst = m_inst;
        e.vld  = m_vld;
        e.to   = m_to;
        e.sc   = m_sc;
        e.fc   = m_fc;
        q.push_back(e);
        if (fl) begin
            m_pc   = pc;
            m_inst = NOP_W;
            m_vld  = 1'b0;
            m_sq   = FD - 1;
        end else if (squashing) begin
            m_inst = NOP_W;
            m_vld  = 1'b0;
            m_sq   = m_sq - 1;
        end else if (!bs) begin
            m_pc   = pc;
            m_inst = inst;
            m_vld  = 1'b1;
        end
        if (stall) begin
            m_run = (m_run < 255) ? m_run + 1 : 255;
            if (m_run == MS) m_to = 1'b1;
        end else begin
            m_run = 0;
        end
`ifdef HAZARD_PERF_CNT_EN
        m_sc = m_sc + 32'(stall);
        m_fc = m_fc + 32'(fl);
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_cycles(input int n, input int pbs, input int pfl);
        for (int i = 0; i < n; i++) begin
            logic bs;
            logic fl;
            bs = ($urandom_range(99) < pbs);
            fl = ($urandom_range(99) < pfl);
            cycle(bs, fl, pc_ctr, $urandom);
            pc_ctr = pc_ctr + 32'd4;
        end
    endtask

    // Asynchronous reset pulse in the middle of a low clock phase, with the current hazard inputs still applied.
    task automatic reset_mid_cycle();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_id_inst", id_inst, NOP_W);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_timeout", 32'(stall_timeout), 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_flush_cnt", flush_cnt, 32'd0);
        bubble_stop = 1'b0;
        flush       = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("rst_pc_write", 32'(pc_write), 32'd1);
        chk("rst_bubble", 32'(id_ex_bubble), 32'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc_write", 32'(pc_write), 32'(e.pcw));
                chk("id_ex_bubble", 32'(id_ex_bubble), 32'(e.bub));
                chk("id_valid", 32'(id_valid), 32'(e.vld));
                chk("id_inst", id_inst, e.inst);
                if (e.vld) chk("id_pc", id_pc, e.pc);
                chk("stall_timeout", 32'(stall_timeout), 32'(e.to));
                chk("stall_cnt", stall_cnt, e.sc);
                chk("flush_cnt", flush_cnt, e.fc);
            end
        end
    end

    initial begin : stim
        int w;
        model_reset();
        pc_ctr = 32'h100;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_id_pc", id_pc, 32'd0);
        chk("reset_id_inst", id_inst, NOP_W);
        chk("reset_id_valid", 32'(id_valid), 32'd0);
        chk("reset_timeout", 32'(stall_timeout), 32'd0);
        rst = 1'b0;
        chk("reset_pc_write", 32'(pc_write), 32'd1);
        chk("reset_bubble", 32'(id_ex_bubble), 32'd0);

        // plain stream, then a one-cycle stall at 0x8
        cycle(1'b0, 1'b0, 32'h0, 32'h00100093);
        cycle(1'b0, 1'b0, 32'h4, 32'h00200113);
        cycle(1'b1, 1'b0, 32'h8, 32'h00308193);
        cycle(1'b0, 1'b0, 32'h8, 32'h00308193);
        cycle(1'b0, 1'b0, 32'hC, 32'h00410213);
        // flush squashing two loads
        cycle(1'b0, 1'b1, 32'h10, 32'h00518293);
        cycle(1'b0, 1'b0, 32'h14, 32'h00620313);
        cycle(1'b0, 1'b0, 32'h18, 32'h00728393);
        cycle(1'b0, 1'b0, 32'h1C, 32'h00830413);
        // flush and stall together, then a stall during the squash tail
        cycle(1'b1, 1'b1, 32'h20, 32'h00938493);
        cycle(1'b1, 1'b0, 32'h24, 32'h00A40513);
        cycle(1'b0, 1'b0, 32'h28, 32'h00B48593);
        cycle(1'b0, 1'b0, 32'h2C, 32'h00C50613);
        // long stall trips the watchdog, which stays set afterwards
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h30, 32'h00D58693);
        cycle(1'b0, 1'b0, 32'h30, 32'h00D58693);
        cycle(1'b0, 1'b0, 32'h34, 32'h00E60713);
        cycle(1'b0, 1'b0, 32'h38, 32'h00F68793);
        // reset in the middle of a stall
        cycle(1'b1, 1'b0, 32'h3C, 32'h01070813);
        cycle(1'b1, 1'b0, 32'h3C, 32'h01070813);
        reset_mid_cycle();
        cycle(1'b0, 1'b0, 32'h40, 32'h01178893);
        cycle(1'b0, 1'b0, 32'h44, 32'h01280913);

        rnd_cycles(400, 35, 12);
        // reset in the middle of a squash
        cycle(1'b0, 1'b1, pc_ctr, $urandom);
        reset_mid_cycle();
        rnd_cycles(400, 60, 5);
        rnd_cycles(200, 20, 30);

        w = 0;
        while (q.size() > 0 && w < 10) begin
            @(negedge clk);
            w++;
        end
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_id_hazard_reg.md
# if_id_hazard_reg

IF/ID pipeline register with built-in hazard response for the 5-stage RV32I core. Consumes the `bubble_stop` request from the stall unit and the taken-branch/jump `flush` from EX, and from them controls the PC write enable, the IF/ID hold, ID/EX bubble insertion and wrong-path squashing. It is the acting end of the stall/flush protocol: the stall unit decides, this block executes. It sits between the instruction-fetch stage and the decode stage.

## Interface

Parameters:
- `FLUSH_DEPTH`, 1: number of IF/ID loads squashed per flush, counting the flush cycle itself. Range 1..3.
- `MAX_STALL`, 15: consecutive stall cycles that trip the watchdog. Range 1..255.
- `NOP`, 32'h00000013: instruction word loaded into squashed or reset slots (`addi x0,x0,0`).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `bubble_stop`  in  1  load-use or jump-dependency stall request from the stall unit.
- `flush`  in  1  branch/jump taken, resolved in EX; wrong-path instructions must be removed.
- `if_pc`  in  32  PC of the instruction being fetched.
- `if_inst`  in  32  fetched instruction word.
- `pc_write`  out  1  PC register write enable.
- `id_pc`  out  32  registered PC presented to decode.
- `id_inst`  out  32  registered instruction presented to decode.
- `id_valid`  out  1  `id_inst` is a real, architecturally live instruction.
- `id_ex_bubble`  out  1  ID/EX must load a bubble (control zeroed) this cycle.
- `stall_timeout`  out  1  sticky watchdog flag.
- `stall_cnt`  out  32  total stall cycles (see Configuration).
- `flush_cnt`  out  32  total flush events (see Configuration).

## Operation

- States: RUN, STALL, SQUASH. Reset enters RUN.
- Priority: `flush` beats `bubble_stop` in every state.
- RUN:
  - `flush`: load `NOP`/`if_pc`, `id_valid`=0. Go to SQUASH with `sq_left`=`FLUSH_DEPTH`-1 if `FLUSH_DEPTH`>1, else stay in RUN.
  - `bubble_stop`: hold `id_*`, `pc_write`=0, `id_ex_bubble`=1, go to STALL.
  - Otherwise: load `if_pc`/`if_inst`, `id_valid`=1.
- STALL:
  - `bubble_stop` still high: keep holding and keep `id_ex_bubble`=1.
  - `bubble_stop` low: load from IF, return to RUN.
  - `flush` is handled as in RUN.
- SQUASH: each cycle load `NOP`, `id_valid`=0, `pc_write`=1, decrement `sq_left`. Return to RUN when it reaches 0. `bubble_stop` is ignored. A new `flush` reloads `sq_left`=`FLUSH_DEPTH`-1.
- `pc_write`, `id_ex_bubble`: combinational from the state and the current inputs.
  - `pc_write` = ~(`bubble_stop` & ~`flush` & state≠SQUASH).
  - `id_ex_bubble` = `bubble_stop` & ~`flush` & state≠SQUASH.
- Watchdog:
  - 8-bit `stall_run` counts consecutive cycles with `id_ex_bubble`=1. It saturates at 255 and clears on any non-stall cycle.
  - When `stall_run` reaches `MAX_STALL`, `stall_timeout` sets. It stays set until reset.

## Timing

- Reset values: `id_pc`=0, `id_inst`=`NOP`, `id_valid`=0, `stall_timeout`=0, `stall_cnt`=0, `flush_cnt`=0, `sq_left`=0. Combinational outputs with inputs low: `pc_write`=1, `id_ex_bubble`=0.
- An IF→ID load appears on `id_*` one cycle after the edge; latency 1.
- A stall asserted in cycle N freezes `id_*` across edge N. Loading resumes at the first edge where `bubble_stop`=0.
- `flush` and `bubble_stop` in the same cycle: flush wins; `pc_write`=1, `id_ex_bubble`=0.
- Reset asserted mid-stall or mid-squash: outputs go to their reset values immediately (asynchronous). State returns to RUN.
- `stall_timeout` rises on the edge that makes `stall_run`==`MAX_STALL`.

## Configuration

- `HAZARD_PERF_CNT_EN`
  - Defined: `stall_cnt` increments on every edge with `id_ex_bubble`=1; `flush_cnt` increments on every edge with `flush`=1. Both are 32-bit and wrap from 0xFFFFFFFF to 0.
  - Undefined: both outputs are tied to 0 and no counter flops are built.

## Test plan

- Reset, then stream PCs 0x0,0x4,0x8 with no hazards → `id_pc` follows one cycle later, `id_valid`=1, `pc_write`=1 throughout.
- `bubble_stop` high for 1 cycle at PC 0x8 → `id_pc` holds 0x4 for two cycles, `id_ex_bubble`=1 for exactly one cycle, `stall_cnt`=1.
- `FLUSH_DEPTH`=2, `flush` pulse at PC 0x10 → next two `id_inst`=0x00000013 with `id_valid`=0, then normal loading resumes; `flush_cnt`=1.
- `flush` and `bubble_stop` together → `pc_write`=1, `id_ex_bubble`=0, `id_inst`=NOP.
- `MAX_STALL`=4, `bubble_stop` held 6 cycles → `stall_timeout` rises on the 4th stall edge and stays high after the stall ends.
- Async `rst` pulse mid-stall (not clock-aligned) → `id_inst`=NOP and `id_valid`=0 immediately; after release, `pc_write`=1 and loading restarts.
